// File: rtl/sysbus_arbiter.sv
// Two-port round-robin arbiter and line-transfer sequencer for the 64-bit Sysbus.
// Port 0 issues line reads; port 1 issues line reads or writes. Response beats are routed back by tag id.
module sysbus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0_valid,
    input  logic [BUS_DATA_WIDTH-1:0] req0_addr,
    input  logic                      req1_valid,
    input  logic                      req1_write,
    input  logic [BUS_DATA_WIDTH-1:0] req1_addr,
    input  logic [BUS_DATA_WIDTH-1:0] req1_wdata,
    output logic                      req1_wbeat,
    output logic                      resp0_valid,
    output logic                      resp1_valid,
    output logic [BUS_DATA_WIDTH-1:0] resp_data,
    output logic                      resp_last,
    output logic                      req0_done,
    output logic                      req1_done,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int unsigned    CNT_W         = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic           SYSBUS_READ   = 1'b0;
    localparam logic           SYSBUS_WRITE  = 1'b1;
    localparam logic [3:0]     SYSBUS_MEMORY = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                    r_state,      w_state_nxt;
    logic                      r_owner,      w_owner_nxt;
    logic                      r_last_grant, w_last_grant_nxt;
    logic [CNT_W-1:0]          r_count,      w_count_nxt;
    logic [BUS_DATA_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic                      r_write,      w_write_nxt;
    logic                      w_grant;
    logic                      w_match;
    logic [BUS_TAG_WIDTH-1:0]  w_tag;
    logic                      w_unused_tag;

    // Only the id field of the response tag selects the destination port.
    assign w_unused_tag = ^bus_resptag[BUS_TAG_WIDTH-1:8];
    assign w_match      = (bus_resptag[7:0] == 8'(r_owner));
    assign w_tag        = BUS_TAG_WIDTH'({r_write ? SYSBUS_WRITE : SYSBUS_READ,
                                          SYSBUS_MEMORY, 7'b0, r_owner});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_count      <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_count      <= w_count_nxt;
            r_addr       <= w_addr_nxt;
            r_write      <= w_write_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_count_nxt      = r_count;
        w_addr_nxt       = r_addr;
        w_write_nxt      = r_write;
        w_grant          = 1'b0;
        req1_wbeat       = 1'b0;
        resp0_valid      = 1'b0;
        resp1_valid      = 1'b0;
        resp_data        = '0;
        resp_last        = 1'b0;
        req0_done        = 1'b0;
        req1_done        = 1'b0;
        bus_reqcyc       = 1'b0;
        bus_respack      = 1'b0;
        bus_req          = '0;
        bus_reqtag       = '0;

        case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the port that did not win last time goes first.
                    w_grant          = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
                    w_owner_nxt      = w_grant;
                    w_last_grant_nxt = w_grant;
                    w_addr_nxt       = w_grant ? req1_addr : req0_addr;
                    w_write_nxt      = w_grant & req1_write;
                    w_state_nxt      = S_REQ;
                end
            end
            S_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = r_addr;
                bus_reqtag = w_tag;
                if (bus_reqack) begin
                    w_count_nxt = '0;
                    w_state_nxt = r_write ? S_WDATA : S_RESP;
                end
            end
            S_WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = req1_wdata;
                bus_reqtag = w_tag;
                if (bus_reqack) begin
                    req1_wbeat = 1'b1;
                    if (r_count == LAST_BEAT) begin
                        req1_done   = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            S_RESP: begin
                bus_respack = bus_respcyc;
                // Beats tagged for another id are acked and dropped without counting.
                if (bus_respcyc && w_match) begin
                    resp0_valid = ~r_owner;
                    resp1_valid = r_owner;
                    resp_data   = bus_resp;
                    if (r_count == LAST_BEAT) begin
                        resp_last   = 1'b1;
                        req0_done   = ~r_owner;
                        req1_done   = r_owner;
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The owning requester must hold its valid for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset && r_state != S_IDLE)
            assert (r_owner ? req1_valid : req0_valid);
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: directed scenarios followed by randomized traffic,
// with expectations derived from a transaction-level model of grants, beats and handshakes.
module tb_sysbus_arbiter;

    localparam logic [63:0] ALLGOOD = 64'h5555_5555_5555_5555;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req1_write;
    logic [63:0] req0_addr, req1_addr, req1_wdata;
    logic        req1_wbeat, resp0_valid, resp1_valid, resp_last, req0_done, req1_done;
    logic [63:0] resp_data, bus_req, bus_resp;
    logic        bus_reqcyc, bus_respack, bus_respcyc, bus_reqack;
    logic [12:0] bus_reqtag, bus_resptag;

    always #5 clk = ~clk;

    sysbus_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wbeat(req1_wbeat),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
        .resp_last(resp_last), .req0_done(req0_done), .req1_done(req1_done),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bit          last_g;
    logic        e_reqcyc, e_respack, e_wbeat, e_r0v, e_r1v, e_last, e_d0, e_d1;
    logic [63:0] e_req, e_data;
    logic [12:0] e_tag;
    logic [63:0] wd [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_clear();
        e_reqcyc = 0; e_respack = 0; e_wbeat = 0; e_r0v = 0; e_r1v = 0;
        e_last = 0; e_d0 = 0; e_d1 = 0; e_req = '0; e_data = '0; e_tag = '0;
    endtask

    task automatic chk_outs(input string w);
        chk({w, ".reqcyc"},  64'(bus_reqcyc),  64'(e_reqcyc));
        chk({w, ".req"},     bus_req,          e_req);
        chk({w, ".reqtag"},  64'(bus_reqtag),  64'(e_tag));
        chk({w, ".respack"}, 64'(bus_respack), 64'(e_respack));
        chk({w, ".wbeat"},   64'(req1_wbeat),  64'(e_wbeat));
        chk({w, ".r0v"},     64'(resp0_valid), 64'(e_r0v));
        chk({w, ".r1v"},     64'(resp1_valid), 64'(e_r1v));
        chk({w, ".rdata"},   resp_data,        e_data);
        chk({w, ".rlast"},   64'(resp_last),   64'(e_last));
        chk({w, ".done0"},   64'(req0_done),   64'(e_d0));
        chk({w, ".done1"},   64'(req1_done),   64'(e_d1));
    endtask

    // Inputs are driven just after posedge; outputs are checked on the following negedge.
    task automatic cyc(input string w);
        @(negedge clk);
        chk_outs(w);
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick();
        return (req0_valid && req1_valid) ? ~last_g : req1_valid;
    endfunction

    // One transaction from its grant cycle in IDLE through completion (or reset at beat abort_at).
    task automatic run_txn(input bit port, input bit wr, input int ack_dly, input bit rnd,
                           input logic [31:0] wpat, input logic [63:0] rpat, input int abort_at);
        logic [63:0] addr;
        logic [12:0] tg;
        logic [63:0] rd;
        logic [7:0]  sid;
        int          k, cnt, code;
        bit          ack, good, aborted;
        addr    = port ? req1_addr : req0_addr;
        tg      = (wr ? 13'h1100 : 13'h0100) | 13'(port);
        aborted = 0;
        k       = 0;
        cnt     = 0;
        last_g  = port;
        exp_clear();
        cyc("idle");
        for (int d = 0; d <= ack_dly; d++) begin
            bus_reqack = (d == ack_dly);
            exp_clear(); e_reqcyc = 1; e_req = addr; e_tag = tg;
            cyc("req");
        end
        bus_reqack = 0;
        if (wr) begin
            while (k < 8 && cnt < 200) begin
                ack = rnd ? 1'($urandom_range(0, 1)) : (cnt < 32 ? wpat[cnt] : 1'b1);
                req1_wdata = wd[k];
                bus_reqack = ack;
                exp_clear(); e_reqcyc = 1; e_req = wd[k]; e_tag = tg;
                e_wbeat = ack; e_d1 = ack && (k == 7);
                cyc("wdata");
                if (ack) k++;
                cnt++;
            end
            bus_reqack = 0;
            req1_wdata = '0;
        end else begin
            while (k < 8 && cnt < 200) begin
                code = rnd ? int'($urandom_range(0, 3)) : (cnt < 32 ? int'(rpat[2*cnt +: 2]) : 1);
                good = (code == 1 || code == 3);
                rd   = {$urandom, $urandom};
                if (code == 2)
                    sid = (rnd && $urandom_range(0, 1) == 1) ? 8'(!port) : 8'h05;
                else
                    sid = 8'(port);
                bus_respcyc = (code != 0);
                bus_resp    = rd;
                bus_resptag = {5'b00001, sid};
                exp_clear(); e_respack = (code != 0);
                if (good) begin
                    e_r0v = !port; e_r1v = port; e_data = rd; e_last = (k == 7);
                    e_d0 = !port && (k == 7); e_d1 = port && (k == 7);
                end
                if (good && k == abort_at) begin
                    #1 chk_outs("pre_rst");
                    reset = 0;
                    #1 exp_clear();
                    chk_outs("rst_mid");
                    aborted = 1;
                    break;
                end
                cyc("resp");
                if (good) k++;
                cnt++;
            end
            bus_respcyc = 0;
            bus_resp    = '0;
            bus_resptag = '0;
        end
        if (!aborted) chk("beats", 64'(k), 64'd8);
        if (port) req1_valid = 0; else req0_valid = 0;
    endtask

    initial begin
        bit w, wr;
        reset = 0;
        req0_valid = 0; req1_valid = 0; req1_write = 0;
        req0_addr = '0; req1_addr = '0; req1_wdata = '0;
        bus_respcyc = 0; bus_reqack = 0; bus_resp = '0; bus_resptag = '0;
        last_g = 1;
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1; bus_respcyc = 1;
        exp_clear();
        repeat (2) cyc("in_reset");
        req0_valid = 0; req1_valid = 0; bus_respcyc = 0;
        reset = 1;

        // Contention from reset: port 0 first (reqack after 2 waits), then port 1 back to back.
        req0_valid = 1; req0_addr = 64'h1000;
        req1_valid = 1; req1_addr = 64'h3000; req1_write = 0;
        run_txn(0, 0, 2, 0, '0, ALLGOOD, 8);
        run_txn(1, 0, 0, 0, '0, ALLGOOD, 8);
        req0_valid = 1; req0_addr = 64'h1040;
        req1_valid = 1; req1_addr = 64'h3040;
        run_txn(0, 0, 1, 0, '0, ALLGOOD, 8);
        run_txn(1, 0, 1, 0, '0, ALLGOOD, 8);

        // Port 1 line write with irregular acks, then a stray response while idle.
        for (int i = 0; i < 8; i++) wd[i] = 64'(i);
        req1_valid = 1; req1_write = 1; req1_addr = 64'h2000;
        run_txn(1, 1, 1, 0, 32'h0000_076D, '0, 8);
        req1_write = 0;
        bus_respcyc = 1; bus_resptag = 13'h0101; bus_resp = 64'hDEAD;
        exp_clear();
        cyc("post_wr");
        bus_respcyc = 0; bus_resptag = '0; bus_resp = '0;

        // Read with gaps and one stray beat tagged id 0x05.
        req0_valid = 1; req0_addr = 64'h4000;
        run_txn(0, 0, 0, 0, '0, 64'h5555_5555_5554_5811, 8);

        // Reset during beat 4, then a clean port 1 read.
        req0_valid = 1; req0_addr = 64'h5000;
        run_txn(0, 0, 0, 0, '0, ALLGOOD, 3);
        exp_clear();
        repeat (2) cyc("held_rst");
        reset = 1;
        last_g = 1;
        req1_valid = 1; req1_write = 0; req1_addr = 64'h6000;
        run_txn(1, 0, 1, 0, '0, ALLGOOD, 8);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1;
                req0_addr  = {$urandom, $urandom} & ~64'h3F;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1;
                req1_write = 1'($urandom_range(0, 1));
                req1_addr  = {$urandom, $urandom} & ~64'h3F;
            end
            if (!req0_valid && !req1_valid) begin
                exp_clear();
                cyc("idle_empty");
            end else begin
                w  = pick();
                wr = w ? req1_write : 1'b0;
                if (wr) for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
                run_txn(w, wr, int'($urandom_range(0, 3)), 1, '0, '0, 8);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Two-port arbiter and transaction sequencer for the single 64-bit system bus. Port 0 (instruction fetch) issues line reads; port 1 (data memory) issues line reads and line writes. The block picks one requester by round-robin, drives the Sysbus request handshake, streams write beats or collects response beats, and routes response data back to the owning port. It sits between the fetch/memory stages and the top-level `bus_*` pins.

## Interface
- `BUS_DATA_WIDTH`, 64, bus beat width
- `BUS_TAG_WIDTH`, 13, tag width: {rw[12], type[11:8], id[7:0]}
- `BEATS`, 8, beats per line transfer (64-byte line)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  fetch read request, held until `req0_done`
- `req0_addr`  in  64  fetch line address
- `req1_valid`  in  1  data request, held until `req1_done`
- `req1_write`  in  1  1 = line write, 0 = line read
- `req1_addr`  in  64  data line address
- `req1_wdata`  in  64  current write beat
- `req1_wbeat`  out  1  pulse: current write beat accepted; present next beat next cycle
- `resp0_valid`, `resp1_valid`  out  1  read beat valid for that port
- `resp_data`  out  64  read beat, shared by both ports
- `resp_last`  out  1  final beat of line
- `req0_done`, `req1_done`  out  1  one-cycle pulse: transaction complete
- `bus_reqcyc`, `bus_respack`  out  1  Sysbus request valid / response ack
- `bus_req`  out  BUS_DATA_WIDTH  address or write data
- `bus_reqtag`  out  BUS_TAG_WIDTH  request tag
- `bus_respcyc`, `bus_reqack`  in  1  Sysbus response valid / request ack
- `bus_resp`  in  BUS_DATA_WIDTH  response beat
- `bus_resptag`  in  BUS_TAG_WIDTH  response tag

## Operation
- States: IDLE, REQ, WDATA, RESP. Registers: state, owner (1b), last_grant (1b), beat count (log2 BEATS), latched addr/write.
- IDLE: if any `reqN_valid`, grant; both valid -> grant port != last_grant. Latch owner, addr, write (port 0 write = 0); last_grant <= owner; go REQ.
- REQ: `bus_reqcyc`=1, `bus_req`=latched addr, `bus_reqtag`={write ? SYSBUS_WRITE : SYSBUS_READ, SYSBUS_MEMORY, 7'b0, owner}. On `bus_reqack`: write -> WDATA, read -> RESP; count <= 0.
- WDATA: `bus_reqcyc`=1, `bus_req`=`req1_wdata`, tag unchanged. Each cycle with `bus_reqack`: `req1_wbeat`=1, count++. Beat BEATS-1 accepted -> `req1_done`=1, IDLE. Writes expect no response.
- RESP: `bus_respack` = `bus_respcyc`. Beat with `bus_resptag[7:0]`==owner: `respN_valid`=1 for owner, `resp_data`=`bus_resp`, count++; count==BEATS-1 -> `resp_last`=1, `reqN_done`=1, IDLE. Mismatched-tag beats are acked and dropped, not counted.
- All outputs not listed for a state are 0; `bus_req`/`resp_data` are don't-care when their valids are low but must not be X in simulation (drive 0).

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, count 0, owner 0, last_grant 1 (port 0 wins first tie); all outputs 0 immediately, including mid-transaction. Bus-side cleanup after mid-transfer reset is the bus's responsibility.
- Request latency: `reqN_valid` sampled high in IDLE -> `bus_reqcyc` high next cycle.
- `bus_reqcyc` stays high until acked; address and tag stable while waiting.
- Read beats forwarded combinationally, same cycle as `bus_respcyc`; no buffering; requesters always accept.
- Done pulse coincides with last beat (read) or last write-beat accept; IDLE can grant again on the following cycle, so minimum gap between transactions is 1 IDLE cycle.
- Requests arriving during a transaction wait; `req_valid` dropping mid-transaction is illegal (assertion).
- Count wraps only via return to IDLE; never exceeds BEATS-1.

## Test plan
- Port 0 read 0x1000, reqack after 2 cycles, 8 beats tag id 0 -> `bus_reqcyc` 3 cycles, tag {READ,MEMORY,0x00}, 8 `resp0_valid`, `resp_last`+`req0_done` on beat 8, `bus_respack` each beat.
- Both ports valid from reset -> port 0 granted first, port 1 (id 0x01) granted immediately after port 0 done; repeated contention alternates grants.
- Port 1 write 0x2000 data 0..7, reqack irregular (1,0,1,1,0...) -> 8 `req1_wbeat` pulses exactly on acked cycles, bus_req sequence 0x2000,0..7, `req1_done` on 8th, no RESP state.
- Read with idle gaps between response beats and one stray beat tag id 0x05 -> stray acked and dropped, owner receives exactly 8 beats.
- Assert `reset` low during beat 4 of a read -> all outputs 0 same cycle; after release, new port 1 read starts cleanly with count 0.
